// File: rtl/udp_rx_pkt_fifo_pkg.sv
// Shared defaults and FSM state encodings for the UDP receive packet FIFO.
package udp_rx_pkt_fifo_pkg;

  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_LEN_AW  = 4;
  localparam int DEF_MAX_PKT = 1472;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_BAD  = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/udp_rx_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one synchronous read port (1-cycle latency).
module udp_rx_sdp_ram
  import udp_rx_pkt_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              rgmii_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  // Read data holds when rd_en is low so a stalled consumer keeps its prefetched byte.
  always_ff @(posedge rgmii_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_rx_pkt_fifo.sv
// Store-and-forward UDP payload FIFO: only complete, length-consistent packets reach the
// streaming output; truncated, oversized or unroutable packets are rolled back and counted.
module udp_rx_pkt_fifo
  import udp_rx_pkt_fifo_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_AW  = DEF_LEN_AW,
  parameter int MAX_PKT = DEF_MAX_PKT
) (
  input  logic            rgmii_clk,
  input  logic            rstn,
  input  logic            udp_rec_data_valid,
  input  logic [7:0]      udp_rec_rdata,
  input  logic [15:0]     udp_rec_data_length,
  output logic            m_valid,
  output logic [7:0]      m_data,
  output logic            m_sop,
  output logic            m_eop,
  input  logic            m_ready,
  output logic [15:0]     drop_cnt,
  output logic [ADDR_W:0] free_bytes
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam int LF_DEPTH = 2**LEN_AW;

  wr_state_t       ws;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] commit_ptr;
  logic [15:0]     wr_cnt;
  logic [15:0]     wr_len;

  rd_state_t       rs;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] fe_ptr;
  logic [15:0]     rd_len;
  logic [15:0]     rd_fcnt;
  logic [15:0]     rd_ocnt;

  logic [15:0]     lf_mem [LF_DEPTH];
  logic [LEN_AW:0] lf_wp;
  logic [LEN_AW:0] lf_rp;
  logic [15:0]     lf_dout;
  logic            lf_full;
  logic            lf_empty;
  logic            lf_push;
  logic            lf_pop;

  logic            start_ok;
  logic            ram_we;
  logic            ram_re;
  logic            wr_drop;
  logic            xfer;
  logic            more;
  logic [7:0]      ram_q;

  // rd_ptr tracks consumed bytes, so prefetched-but-unaccepted bytes still count as occupied.
  assign free_bytes = DEPTH - (wr_ptr - rd_ptr);

  assign lf_empty = (lf_wp == lf_rp);
  assign lf_full  = (lf_wp[LEN_AW] != lf_rp[LEN_AW]) &&
                    (lf_wp[LEN_AW-1:0] == lf_rp[LEN_AW-1:0]);
  assign lf_dout  = lf_mem[lf_rp[LEN_AW-1:0]];

  assign start_ok = (udp_rec_data_length != 16'd0) &&
                    (32'(udp_rec_data_length) <= 32'(MAX_PKT)) &&
                    (32'(udp_rec_data_length) <= 32'(free_bytes)) &&
                    !lf_full;

  always_comb begin
    ram_we  = 1'b0;
    lf_push = 1'b0;
    wr_drop = 1'b0;
    unique case (ws)
      W_IDLE: ram_we = udp_rec_data_valid && start_ok;
      W_RECV: begin
        if (udp_rec_data_valid) begin
          ram_we = (wr_cnt != wr_len);
        end else begin
          lf_push = (wr_cnt == wr_len);
          wr_drop = (wr_cnt != wr_len);
        end
      end
      W_BAD:   wr_drop = !udp_rec_data_valid;
      default: ;
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      ws         <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wr_cnt     <= '0;
      wr_len     <= '0;
      drop_cnt   <= '0;
      lf_wp      <= '0;
    end else begin
      unique case (ws)
        W_IDLE: begin
          if (udp_rec_data_valid) begin
            if (start_ok) begin
              ws     <= W_RECV;
              wr_len <= udp_rec_data_length;
              wr_cnt <= 16'd1;
              wr_ptr <= wr_ptr + 1'b1;
            end else begin
              ws <= W_BAD;
            end
          end
        end
        W_RECV: begin
          if (udp_rec_data_valid) begin
            if (wr_cnt == wr_len) begin
              ws <= W_BAD;
            end else begin
              wr_cnt <= wr_cnt + 16'd1;
              wr_ptr <= wr_ptr + 1'b1;
            end
          end else begin
            ws <= W_IDLE;
            if (lf_push) commit_ptr <= wr_ptr;
            else         wr_ptr     <= commit_ptr;
          end
        end
        W_BAD: begin
          if (!udp_rec_data_valid) begin
            ws     <= W_IDLE;
            wr_ptr <= commit_ptr;
          end
        end
        default: ws <= W_IDLE;
      endcase
      if (wr_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
      if (lf_push) lf_wp <= lf_wp + 1'b1;
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (lf_push) lf_mem[lf_wp[LEN_AW-1:0]] <= wr_len;
  end

  assign xfer = m_valid && m_ready;
  assign more = (rd_fcnt < rd_len);

  // The RAM runs one byte ahead of the output register; on the eop transfer the next
  // packet's first byte is fetched immediately, leaving a single idle output cycle.
  always_comb begin
    lf_pop = 1'b0;
    ram_re = 1'b0;
    unique case (rs)
      R_IDLE: begin
        lf_pop = !lf_empty;
        ram_re = !lf_empty;
      end
      R_FETCH: ram_re = more;
      R_DATA: begin
        if (xfer) begin
          if (m_eop) begin
            lf_pop = !lf_empty;
            ram_re = !lf_empty;
          end else begin
            ram_re = more;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      rs      <= R_IDLE;
      rd_ptr  <= '0;
      fe_ptr  <= '0;
      rd_len  <= '0;
      rd_fcnt <= '0;
      rd_ocnt <= '0;
      lf_rp   <= '0;
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_data  <= '0;
    end else begin
      if (ram_re) fe_ptr <= fe_ptr + 1'b1;
      if (xfer)   rd_ptr <= rd_ptr + 1'b1;
      if (lf_pop) begin
        lf_rp   <= lf_rp + 1'b1;
        rd_len  <= lf_dout;
        rd_fcnt <= 16'd1;
      end
      unique case (rs)
        R_IDLE: if (lf_pop) rs <= R_FETCH;
        R_FETCH: begin
          rs      <= R_DATA;
          m_valid <= 1'b1;
          m_sop   <= 1'b1;
          m_eop   <= (rd_len == 16'd1);
          m_data  <= ram_q;
          rd_ocnt <= '0;
          if (ram_re) rd_fcnt <= rd_fcnt + 16'd1;
        end
        R_DATA: begin
          if (xfer) begin
            if (m_eop) begin
              m_valid <= 1'b0;
              m_sop   <= 1'b0;
              m_eop   <= 1'b0;
              rs      <= lf_pop ? R_FETCH : R_IDLE;
            end else begin
              m_data  <= ram_q;
              m_sop   <= 1'b0;
              m_eop   <= ((17'(rd_ocnt) + 17'd2) == 17'(rd_len));
              rd_ocnt <= rd_ocnt + 16'd1;
              if (ram_re) rd_fcnt <= rd_fcnt + 16'd1;
            end
          end
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  udp_rx_sdp_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .rgmii_clk(rgmii_clk),
    .wr_en    (ram_we),
    .wr_addr  (wr_ptr[ADDR_W-1:0]),
    .wr_data  (udp_rec_rdata),
    .rd_en    (ram_re),
    .rd_addr  (fe_ptr[ADDR_W-1:0]),
    .rd_data  (ram_q)
  );

endmodule

// File: tb/tb_udp_rx_pkt_fifo.sv
// Bench for udp_rx_pkt_fifo: random payloads checked against a packet-level acceptance model.
module tb_udp_rx_pkt_fifo;

  localparam int DEPTH = 2048;
  localparam int MAXP  = 1472;
  localparam int LFD   = 16;

  logic        rgmii_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        udp_rec_data_valid = 1'b0;
  logic [7:0]  udp_rec_rdata = 8'h00;
  logic [15:0] udp_rec_data_length = 16'h0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_sop;
  logic        m_eop;
  logic [15:0] drop_cnt;
  logic [11:0] free_bytes;

  udp_rx_pkt_fifo dut (
    .rgmii_clk          (rgmii_clk),
    .rstn               (rstn),
    .udp_rec_data_valid (udp_rec_data_valid),
    .udp_rec_rdata      (udp_rec_rdata),
    .udp_rec_data_length(udp_rec_data_length),
    .m_valid            (m_valid),
    .m_data             (m_data),
    .m_sop              (m_sop),
    .m_eop              (m_eop),
    .m_ready            (m_ready),
    .drop_cnt           (drop_cnt),
    .free_bytes         (free_bytes)
  );

  always #5 rgmii_clk = ~rgmii_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  logic [9:0] exp_q [$];
  logic [9:0] obs_q [$];
  int obs_cyc [$];
  int exp_drop = 0;
  int exp_pkts = 0;
  int obs_sops = 0;
  int hold_err = 0;
  bit rnd_ready = 1'b0;
  bit stall_prev = 1'b0;
  logic [9:0] prev_out;

  always @(posedge rgmii_clk) cyc <= cyc + 1;

  always @(posedge rgmii_clk) begin
    if (rnd_ready) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: records every accepted byte and flags any change while stalled.
  always @(negedge rgmii_clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && !(m_valid && ({m_sop, m_eop, m_data} === prev_out))) hold_err++;
      if (m_valid && m_ready) begin
        obs_q.push_back({m_sop, m_eop, m_data});
        obs_cyc.push_back(cyc);
        if (m_sop) obs_sops++;
      end
      stall_prev = m_valid && !m_ready;
      prev_out   = {m_sop, m_eop, m_data};
    end
  end

  function automatic bit model_accept(int len, int nbytes, int free, int entries);
    return (len > 0) && (len <= MAXP) && (len <= free) && (entries < LFD) && (nbytes == len);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  task automatic tick();
    @(posedge rgmii_clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    exp_pkts = 0;
    obs_sops = 0;
  endtask

  task automatic send_pkt(input int len, input int nbytes, output int t_low);
    bit ok;
    logic [7:0] d;
    ok = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      tick();
      if (i == 0)
        ok = model_accept(len, nbytes, DEPTH - (exp_q.size() - obs_q.size()), exp_pkts - obs_sops);
      d = 8'($urandom);
      udp_rec_data_valid  = 1'b1;
      udp_rec_data_length = 16'(len);
      udp_rec_rdata       = d;
      if (ok) exp_q.push_back({1'(i == 0), 1'(i == len - 1), d});
    end
    if (ok) exp_pkts++;
    else    exp_drop++;
    tick();
    udp_rec_data_valid = 1'b0;
    t_low = cyc;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && obs_q.size() < exp_q.size(); i++) tick();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({m_valid, m_sop, m_eop, m_data} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 000", {m_valid, m_sop, m_eop, m_data});
    end
    n_tests++;
    if (free_bytes !== 12'(DEPTH)) begin
      n_fail++;
      $display("FAIL reset_free: got %0d required %0d", free_bytes, DEPTH);
    end
    n_tests++;
    if (drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_drop: got %0d required 0", drop_cnt);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t_low, bad, first, last;
    clear_model();
    m_ready = 1'b1;
    send_pkt(20, 20, t_low);
    wait_drain(200);
    bad = first_diff();
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL basic_stream: diff at %0d, got %0d bytes required %0d", bad, obs_q.size(), exp_q.size());
    end
    first = (obs_cyc.size() > 0)  ? obs_cyc[0]  : -1;
    last  = (obs_cyc.size() > 19) ? obs_cyc[19] : -1;
    n_tests++;
    if (first != t_low + 3) begin
      n_fail++;
      $display("FAIL basic_latency: first byte cycle %0d required %0d", first, t_low + 3);
    end
    n_tests++;
    if (last - first != 19) begin
      n_fail++;
      $display("FAIL basic_contiguous: span %0d required 19", last - first);
    end
    n_tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL basic_drop: got %0d required %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_truncated();
    int t_low, bad;
    clear_model();
    m_ready = 1'b1;
    send_pkt(20, 19, t_low);
    repeat (6) tick();
    n_tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL trunc_drop: got %0d required %0d", drop_cnt, exp_drop);
    end
    n_tests++;
    if (free_bytes !== 12'(DEPTH) || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL trunc_empty: free %0d out %0d required free %0d out 0", free_bytes, obs_q.size(), DEPTH);
    end
    send_pkt(20, 20, t_low);
    wait_drain(200);
    bad = first_diff();
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL trunc_followup: diff at %0d, got %0d bytes required %0d", bad, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_drops();
    int t_low;
    clear_model();
    m_ready = 1'b1;
    send_pkt(0, 5, t_low);
    send_pkt(MAXP + 1, 10, t_low);
    send_pkt(20, 21, t_low);
    repeat (10) tick();
    n_tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL drops_count: got %0d required %0d", drop_cnt, exp_drop);
    end
    n_tests++;
    if (obs_q.size() != 0 || free_bytes !== 12'(DEPTH)) begin
      n_fail++;
      $display("FAIL drops_no_output: out %0d free %0d required out 0 free %0d", obs_q.size(), free_bytes, DEPTH);
    end
  endtask

  task automatic test_random();
    int t_low, bad, len, sel, nb;
    clear_model();
    hold_err = 0;
    rnd_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(1, 150);
      sel = $urandom_range(0, 4);
      nb  = (sel == 0 && len > 1) ? len - 1 : ((sel == 1) ? len + 1 : len);
      repeat ($urandom_range(0, 2)) tick();
      send_pkt(len, nb, t_low);
    end
    wait_drain(6000);
    rnd_ready = 1'b0;
    tick();
    m_ready = 1'b1;
    bad = first_diff();
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL random_stream: diff at %0d, got %0d bytes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_tests++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL random_hold: %0d changes while stalled, required 0", hold_err);
    end
    n_tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL random_drop: got %0d required %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_stall_wrap();
    int t_low, bad;
    clear_model();
    hold_err = 0;
    m_ready = 1'b1;
    send_pkt(1000, 1000, t_low);
    wait_drain(2000);
    bad = first_diff();
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL stall_prefill: diff at %0d, got %0d bytes required %0d", bad, obs_q.size(), exp_q.size());
    end
    clear_model();
    m_ready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(1000, 1000, t_low);
    repeat (5) tick();
    n_tests++;
    if (free_bytes !== 12'(DEPTH - 2 * 1000)) begin
      n_fail++;
      $display("FAIL stall_free: got %0d required %0d", free_bytes, DEPTH - 2 * 1000);
    end
    n_tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL stall_drop: got %0d required %0d", drop_cnt, exp_drop);
    end
    n_tests++;
    if ({m_valid, m_sop, m_data} !== {1'b1, 1'b1, exp_q[0][7:0]} || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_present: got v/sop/data %h out %0d required %h out 0",
               {m_valid, m_sop, m_data}, obs_q.size(), {1'b1, 1'b1, exp_q[0][7:0]});
    end
    m_ready = 1'b1;
    wait_drain(5000);
    bad = first_diff();
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL stall_stream: diff at %0d, got %0d bytes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_tests++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d changes while stalled, required 0", hold_err);
    end
  endtask

  task automatic test_reset_mid();
    int t_low, bad;
    clear_model();
    m_ready = 1'b0;
    send_pkt(8, 8, t_low);
    repeat (4) tick();
    n_tests++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre_valid: got %b required 1", m_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      udp_rec_data_valid  = 1'b1;
      udp_rec_data_length = 16'd20;
      udp_rec_rdata       = 8'($urandom);
    end
    @(posedge rgmii_clk);
    #3;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({m_valid, m_sop, m_eop, m_data} !== 11'h000) begin
      n_fail++;
      $display("FAIL rmid_async_outputs: got %h required 000", {m_valid, m_sop, m_eop, m_data});
    end
    n_tests++;
    if (free_bytes !== 12'(DEPTH) || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rmid_async_state: free %0d drop %0d required free %0d drop 0", free_bytes, drop_cnt, DEPTH);
    end
    udp_rec_data_valid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    clear_model();
    exp_drop = 0;
    m_ready = 1'b1;
    tick();
    send_pkt(20, 20, t_low);
    wait_drain(200);
    bad = first_diff();
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL rmid_after: diff at %0d, got %0d bytes required %0d", bad, obs_q.size(), exp_q.size());
    end
    n_tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL rmid_drop: got %0d required %0d", drop_cnt, exp_drop);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_truncated();
    test_drops();
    test_random();
    test_stall_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
